// File: rtl/uart_img_loader_pkg.sv
`timescale 1ns/1ps
// uart_img_loader_pkg
//   Shared definitions for the UART image loader slice:
//   - DEFAULT_CLKS_PER_BIT : 50 MHz / 115200 baud
//   - rx_state_t           : receiver FSM states (R_PAR only used with UART_PARITY_EN)
//   - load_state_t         : loader FSM states
//   - even_parity_ok()     : even-parity check over data byte plus parity bit
package uart_img_loader_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    R_IDLE,
    R_START,
    R_DATA,
    R_PAR,
    R_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    L_IDLE,
    L_LOAD,
    L_START,
    L_WAIT
  } load_state_t;

  // True when data plus parity bit hold an even number of ones.
  function automatic logic even_parity_ok(input logic [7:0] data, input logic par_bit);
    return ~(^{data, par_bit});
  endfunction

endpackage

// File: rtl/uart_img_loader_if.sv
`timescale 1ns/1ps
// uart_img_loader_if
//   Data-memory write bus plus processor start/status handshake.
//   Parameter ADDR_W must match the loader's ADDR_W.
//   Signals:
//     dm_we           write strobe, one cycle per byte
//     dm_addr         write address (ADDR_W bits)
//     dm_wdata        write data (8 bits)
//     processor_start one-cycle start pulse to the processor
//     status          processor done flag
//   Modports: master = loader side, slave = memory/processor side.
interface uart_img_loader_if #(
  parameter int ADDR_W = 19
);

  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [7:0]        dm_wdata;
  logic              processor_start;
  logic              status;

  modport master (
    output dm_we,
    output dm_addr,
    output dm_wdata,
    output processor_start,
    input  status
  );

  modport slave (
    input  dm_we,
    input  dm_addr,
    input  dm_wdata,
    input  processor_start,
    output status
  );

endinterface

// File: rtl/uart_img_loader_uart_rx.sv
`timescale 1ns/1ps
// uart_rx
//   UART receiver: 2-FF synchroniser on rx followed by a mid-bit sampling FSM.
//   Default frame is 8N1, LSB first. With UART_PARITY_EN defined the frame
//   carries an even-parity bit after D7.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     rx          serial input, idle high, asynchronous to clk
//     rx_valid    one-cycle pulse when a byte was received cleanly
//     rx_byte     received byte, valid with rx_valid
//     frame_err   sticky, stop bit sampled low
//     parity_err  sticky, parity mismatch (tied 0 without UART_PARITY_EN)
//   Configuration macro: UART_PARITY_EN
module uart_rx
  import uart_img_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST =
    CNT_W'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);

  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  assign rx_byte = shift;

  // Synchroniser and edge-history flops reset to the idle-high line level so
  // that leaving reset never looks like a start-bit falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

`ifdef UART_PARITY_EN
  logic par_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Receiver FSM. R_START samples half a bit after the falling edge so every
  // later sample, spaced a full bit apart, lands near the middle of its bit.
  // R_STOP goes straight back to R_IDLE on the stop sample, leaving the second
  // half of the stop bit free to detect the next start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= R_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        R_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= R_START;
            clk_cnt <= '0;
          end
        end
        R_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            shift   <= {rx_sync, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= R_PAR;
`else
              state <= R_STOP;
`endif
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`ifdef UART_PARITY_EN
        R_PAR: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            par_bit <= rx_sync;
            state   <= R_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif
        R_STOP: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= R_IDLE;
            if (!rx_sync) begin
              frame_err <= 1'b1;
            end
`ifdef UART_PARITY_EN
            else if (!even_parity_ok(shift, par_bit)) begin
              parity_err <= 1'b1;
            end
`endif
            else begin
              rx_valid <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_img_loader.sv
`timescale 1ns/1ps
// uart_img_loader
//   Receives a source image over UART and writes it byte by byte into data
//   memory starting at DM_BASE. After the last byte it pulses processor_start
//   and holds busy until the processor raises status.
//   Ports:
//     clk         system clock, rising edge
//     RST         asynchronous active-high reset
//     rx          UART serial input, idle high
//     load_arm    one-cycle pulse, accepted only while idle
//     busy        high from arm acceptance until status is seen
//     frame_err   sticky framing error
//     parity_err  sticky parity error (0 without UART_PARITY_EN)
//     mem         uart_img_loader_if.master: dm_we/dm_addr/dm_wdata,
//                 processor_start out, status in
//   Configuration macro: UART_PARITY_EN (even parity bit after D7)
module uart_img_loader
  import uart_img_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int ADDR_W       = 19,
  parameter int IMG_BYTES    = 65536,
  parameter int DM_BASE      = 0
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic                   rx,
  input  logic                   load_arm,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   parity_err,
  uart_img_loader_if.master      mem
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(IMG_BYTES - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DM_BASE);

  logic              rx_valid;
  logic [7:0]        rx_byte;
  load_state_t       state;
  logic [ADDR_W-1:0] count;

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (RST),
    .rx         (rx),
    .rx_valid   (rx_valid),
    .rx_byte    (rx_byte),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  // Loader FSM with registered memory-bus and handshake outputs. dm_addr and
  // dm_wdata are only loaded on a write so they hold between strobes. The
  // counter stops on the final byte instead of incrementing, so it cannot wrap
  // even when the image fills the whole address space.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state               <= L_IDLE;
      count               <= '0;
      busy                <= 1'b0;
      mem.dm_we           <= 1'b0;
      mem.dm_addr         <= '0;
      mem.dm_wdata        <= '0;
      mem.processor_start <= 1'b0;
    end else begin
      mem.dm_we           <= 1'b0;
      mem.processor_start <= 1'b0;
      case (state)
        L_IDLE: begin
          if (load_arm) begin
            state <= L_LOAD;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        L_LOAD: begin
          if (rx_valid) begin
            mem.dm_we    <= 1'b1;
            mem.dm_addr  <= BASE_ADDR + count;
            mem.dm_wdata <= rx_byte;
            if (count == LAST_IDX) begin
              state <= L_START;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        L_START: begin
          mem.processor_start <= 1'b1;
          state               <= L_WAIT;
        end
        L_WAIT: begin
          if (mem.status) begin
            state <= L_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= L_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_img_loader.sv
`timescale 1ns/1ps
// tb_uart_img_loader
//   Self-checking bench for uart_img_loader with CLKS_PER_BIT=4, IMG_BYTES=4,
//   DM_BASE=16. A table of frames with expected outputs covers the basic load,
//   pre-arm bytes and framing errors; hand-written sequences cover glitches,
//   asynchronous reset and parity; a random phase is checked against a
//   reference model of the loading rules. Honours UART_PARITY_EN.
module tb_uart_img_loader;

  localparam int CPB  = 4;
  localparam int AW   = 19;
  localparam int IMG  = 4;
  localparam int BASE = 16;

  typedef struct packed {
    bit          status_pulse;
    bit          arm;
    logic [7:0]  data;
    bit          stop_bit;
    bit          exp_write;
    logic [AW-1:0] exp_addr;
    bit          exp_ferr;
    bit          exp_start;
    bit          exp_busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rx;
  logic load_arm;
  logic busy;
  logic frame_err;
  logic parity_err;

  uart_img_loader_if #(.ADDR_W(AW)) bus ();

  uart_img_loader #(
    .CLKS_PER_BIT (CPB),
    .ADDR_W       (AW),
    .IMG_BYTES    (IMG),
    .DM_BASE      (BASE)
  ) dut (
    .clk        (clk),
    .RST        (rst),
    .rx         (rx),
    .load_arm   (load_arm),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .mem        (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Writes and start pulses observed on the bus; start_q records whether a
  // write strobe was present on the cycle before each start pulse.
  logic [AW+7:0] got_q[$];
  bit            start_q[$];
  bit            prev_we = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dm_we) got_q.push_back({bus.dm_addr, bus.dm_wdata});
      if (bus.processor_start) start_q.push_back(prev_we);
      prev_we = bus.dm_we;
    end else begin
      prev_we = 1'b0;
    end
  end

  // Reference model: counts accepted bytes into the image, not FSM states.
  bit            m_loading;
  bit            m_waiting;
  int            m_n;
  bit            m_ferr;
  bit            m_perr;
  int            m_starts;
  logic [AW+7:0] exp_q[$];

  function automatic void model_reset();
    m_loading = 0; m_waiting = 0; m_n = 0; m_ferr = 0; m_perr = 0; m_starts = 0;
    exp_q.delete();
  endfunction

  function automatic void model_arm();
    if (!m_loading && !m_waiting) begin
      m_loading = 1;
      m_n = 0;
    end
  endfunction

  function automatic void model_status();
    if (m_waiting) m_waiting = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
    if (!stop_ok) m_ferr = 1;
    else if (!par_ok) m_perr = 1;
    else if (m_loading) begin
      exp_q.push_back({AW'(BASE + m_n), d});
      m_n++;
      if (m_n == IMG) begin
        m_loading = 0;
        m_waiting = 1;
        m_starts++;
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit, input bit par_flip);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`else
    if (par_flip) rx = 1'b1;
`endif
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic pulse_arm();
    @(negedge clk) load_arm = 1'b1;
    @(negedge clk) load_arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_status();
    @(negedge clk) bus.status = 1'b1;
    @(negedge clk) bus.status = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_write(input string name, input logic [AW-1:0] addr, input logic [7:0] data);
    logic [AW+7:0] w;
    checkOutput({name, "_cnt"}, got_q.size(), 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      checkOutput({name, "_addr"}, w[AW+7:8], addr);
      checkOutput({name, "_data"}, w[7:0], data);
    end
    got_q.delete();
  endtask

  task automatic check_starts(input string name, input int n);
    checkOutput({name, "_start_cnt"}, start_q.size(), n);
    while (start_q.size() > 0) checkOutput({name, "_start_lat"}, start_q.pop_front(), 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.status_pulse) pulse_status();
    if (v.arm) pulse_arm();
    send_frame(v.data, v.stop_bit, 1'b0);
  endtask

  task automatic compare_model(input int it);
    logic [AW+7:0] g, e;
    string tag;
    tag = $sformatf("rnd%0d", it);
    checkOutput({tag, "_wr_cnt"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      checkOutput({tag, "_wr"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check_starts(tag, m_starts);
    m_starts = 0;
    checkOutput({tag, "_busy"}, busy, m_loading | m_waiting);
    checkOutput({tag, "_ferr"}, frame_err, m_ferr);
    checkOutput({tag, "_perr"}, parity_err, m_perr);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  vec_t       vecs[$];
  int unsigned r;
  logic [7:0] d;

  initial begin
    rx = 1'b1; load_arm = 1'b0; bus.status = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_state",
      {busy, frame_err, parity_err, bus.dm_we, bus.processor_start, bus.dm_addr, bus.dm_wdata}, 32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // status_pulse, arm, data, stop, exp_write, exp_addr, exp_ferr, exp_start, exp_busy
    vecs.push_back('{0, 0, 8'h55, 1, 0, AW'(0),  0, 0, 0});
    vecs.push_back('{0, 1, 8'hA5, 1, 1, AW'(16), 0, 0, 1});
    vecs.push_back('{0, 0, 8'h3C, 1, 1, AW'(17), 0, 0, 1});
    vecs.push_back('{0, 0, 8'hFF, 1, 1, AW'(18), 0, 0, 1});
    vecs.push_back('{0, 0, 8'h00, 1, 1, AW'(19), 0, 1, 1});
    vecs.push_back('{0, 1, 8'h66, 1, 0, AW'(0),  0, 0, 1});
    vecs.push_back('{1, 1, 8'h77, 0, 0, AW'(0),  1, 0, 1});
    vecs.push_back('{0, 0, 8'h12, 1, 1, AW'(16), 1, 0, 1});
    vecs.push_back('{0, 0, 8'h34, 1, 1, AW'(17), 1, 0, 1});
    vecs.push_back('{0, 0, 8'h56, 1, 1, AW'(18), 1, 0, 1});
    vecs.push_back('{0, 0, 8'h78, 1, 1, AW'(19), 1, 1, 1});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      if (vecs[i].exp_write) begin
        check_write($sformatf("row%0d", i), vecs[i].exp_addr, vecs[i].data);
      end else begin
        checkOutput($sformatf("row%0d_no_wr", i), got_q.size(), 0);
        got_q.delete();
      end
      check_starts($sformatf("row%0d", i), vecs[i].exp_start ? 1 : 0);
      checkOutput($sformatf("row%0d_ferr", i), frame_err, vecs[i].exp_ferr);
      checkOutput($sformatf("row%0d_busy", i), busy, vecs[i].exp_busy);
    end

    checkOutput("hold_addr", bus.dm_addr, 32'd19);
    checkOutput("hold_data", bus.dm_wdata, 32'h78);
    pulse_status();
    checkOutput("status_busy", busy, 0);

    // Short low glitch must be rejected without a byte or error.
    do_reset();
    pulse_arm();
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20 * CPB) @(negedge clk);
    checkOutput("glitch_no_wr", got_q.size(), 0);
    checkOutput("glitch_ferr", frame_err, 0);
    send_frame(8'hAB, 1'b1, 1'b0);
    check_write("glitch_next", AW'(16), 8'hAB);
    send_frame(8'hCD, 1'b1, 1'b0);
    check_write("second", AW'(17), 8'hCD);

    // Asynchronous reset in the middle of the third frame.
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset",
      {busy, frame_err, parity_err, bus.dm_we, bus.processor_start, bus.dm_addr, bus.dm_wdata}, 32'h0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    got_q.delete();
    start_q.delete();
    repeat (2) @(negedge clk);
    pulse_arm();
    for (int i = 0; i < IMG; i++) begin
      send_frame(8'(8'h90 + i), 1'b1, 1'b0);
      check_write($sformatf("rearm%0d", i), AW'(BASE + i), 8'(8'h90 + i));
    end
    check_starts("rearm", 1);
    pulse_status();
    checkOutput("rearm_busy", busy, 0);

`ifdef UART_PARITY_EN
    do_reset();
    pulse_arm();
    send_frame(8'h01, 1'b1, 1'b1);
    checkOutput("par_bad_perr", parity_err, 1);
    checkOutput("par_bad_no_wr", got_q.size(), 0);
    got_q.delete();
    send_frame(8'h01, 1'b1, 1'b0);
    check_write("par_good", AW'(16), 8'h01);
`endif

    // Random phase against the reference model.
    do_reset();
    model_reset();
    for (int it = 0; it < 48; it++) begin
      r = $urandom_range(0, 11);
      d = 8'($urandom);
      if (r <= 6) begin
        send_frame(d, 1'b1, 1'b0);
        model_frame(d, 1, 1);
      end else if (r == 7) begin
        send_frame(d, 1'b0, 1'b0);
        model_frame(d, 0, 1);
      end else if (r == 8) begin
`ifdef UART_PARITY_EN
        send_frame(d, 1'b1, 1'b1);
        model_frame(d, 1, 0);
`else
        send_frame(d, 1'b1, 1'b0);
        model_frame(d, 1, 1);
`endif
      end else if (r <= 10) begin
        pulse_arm();
        model_arm();
      end else begin
        pulse_status();
        model_status();
      end
      compare_model(it);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
